// File: rtl/mc_control.sv
// mc_control: multi-cycle main controller for the MIPS datapath.
// Walks each instruction (add, addi, lw, sw, beq, j) through its state
// sequence and drives every datapath enable and mux select from the current
// state. Outputs are Moore-decoded from the state register. FETCH is the one
// exception: its enables are qualified by run, so the debug/step unit can hold
// the core at an instruction boundary.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   run             allow fetch of the next instruction (looked at in FETCH)
//   opcode          IR[31:26], looked at in DECODE and MEMADR
//   PCWrite .. PCSource  datapath enables and mux selects
//   state           current state encoding (debug)
//   instr_done      pulse in the last cycle of every instruction
//   illegal         pulse when DECODE sees an unsupported opcode
//   instr_cnt       retired-instruction counter, wraps at all-ones
module mc_control #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [5:0]           opcode,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic [3:0]           state,
    output logic                 instr_done,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 op_legal;

    // Opcodes DECODE knows how to dispatch.
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    // Next-state: terminal states and any unused encoding fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (instr_done) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode. Held at zero during reset so an aborted instruction
    // cannot issue a strobe and FETCH cannot fire before reset is released.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    if (run) begin
                        MemRead = 1'b1;
                        IRWrite = 1'b1;
                        ALUSrcB = 2'b01;
                        PCWrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    instr_done = !op_legal;
                    illegal    = !op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: a second instance with a 4-bit counter exercises the
// counter wrap. The reference model describes each instruction as the list of
// steps it walks through plus a table of what each step must drive.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        instr_done, illegal;
    logic [31:0] instr_cnt;

    logic        w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
    logic        w_MemtoReg, w_RegDst, w_RegWrite, w_ALUSrcA;
    logic [1:0]  w_ALUSrcB, w_ALUOp, w_PCSource;
    logic [3:0]  w_state;
    logic        w_instr_done, w_illegal;
    logic [3:0]  w_instr_cnt;

    mc_control #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal(illegal), .instr_cnt(instr_cnt)
    );

    mc_control #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD),
        .MemRead(w_MemRead), .MemWrite(w_MemWrite), .IRWrite(w_IRWrite),
        .MemtoReg(w_MemtoReg), .RegDst(w_RegDst), .RegWrite(w_RegWrite),
        .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp),
        .PCSource(w_PCSource), .state(w_state), .instr_done(w_instr_done),
        .illegal(w_illegal), .instr_cnt(w_instr_cnt)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,illegal}
    logic [17:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, instr_done, illegal};

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cnt_model = 32'd0;

    typedef int path_t[$];

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b000010, 6'b000100,
                          6'b001000, 6'b100011, 6'b101011};
    endfunction

    // Steps each instruction walks through, FETCH first.
    function automatic path_t plan(input logic [5:0] op);
        case (op)
            6'b100011: return '{0, 1, 2, 3, 4};   // lw
            6'b101011: return '{0, 1, 2, 5};      // sw
            6'b000000: return '{0, 1, 6, 7};      // add
            6'b001000: return '{0, 1, 10, 11};    // addi
            6'b000100: return '{0, 1, 8};         // beq
            6'b000010: return '{0, 1, 9};         // j
            default:   return '{0, 1};            // illegal
        endcase
    endfunction

    // What the controller must drive in a given step.
    function automatic logic [17:0] expect_sig(input int st, input logic r,
                                               input logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  if (r) begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
            1:  begin asb = 2'b11; done = !is_legal(op); ill = !is_legal(op); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; done = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                asb, aop, pcs, done, ill};
    endfunction

    function automatic logic [5:0] rand_legal();
        logic [5:0] tbl [6] = '{6'b000000, 6'b000010, 6'b000100,
                               6'b001000, 6'b100011, 6'b101011};
        return tbl[$urandom_range(0, 5)];
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
        return op;
    endfunction

    // Runs one instruction from FETCH (called #1 after a rising edge with the
    // FSM in FETCH), optionally stalled first, comparing every cycle.
    task automatic do_instr(input logic [5:0] op, input int stall,
                            input bit drop_run);
        path_t p;
        logic [17:0] e;
        p = plan(op);
        for (int s = 0; s < stall; s++) begin
            run = 1'b0;
            opcode = 6'($urandom);
            @(negedge clk);
            checks++;
            if (state !== 4'd0 || obs !== 18'd0)
                begin errors++; $display("FAIL stall: state=%0d sig=%h, need state=0 sig=0", state, obs); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < p.size(); i++) begin
            run    = (p[i] == 0) ? 1'b1 : (drop_run ? 1'b0 : 1'($urandom));
            opcode = (p[i] == 1 || p[i] == 2) ? op : 6'($urandom);
            @(negedge clk);
            e = expect_sig(p[i], run, op);
            checks++;
            if (state !== 4'(p[i]))
                begin errors++; $display("FAIL state op=%b step=%0d: got %0d need %0d", op, i, state, p[i]); end
            checks++;
            if (obs !== e)
                begin errors++; $display("FAIL outputs op=%b step=%0d: got %h need %h", op, i, obs, e); end
            checks++;
            if (instr_cnt !== cnt_model || w_instr_cnt !== cnt_model[3:0])
                begin errors++; $display("FAIL instr_cnt op=%b step=%0d: got %0d/%0d need %0d/%0d", op, i, instr_cnt, w_instr_cnt, cnt_model, cnt_model[3:0]); end
            @(posedge clk); #1;
            if (e[1]) cnt_model = cnt_model + 32'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; opcode = 6'b100011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 18'd0 || state !== 4'd0 || instr_cnt !== 32'd0 || w_instr_cnt !== 4'd0)
            begin errors++; $display("FAIL reset: sig=%h state=%0d cnt=%0d, need all 0", obs, state, instr_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_model = 32'd0;
    endtask

    task automatic test_abort();
        do_instr(6'b100011, 0, 1'b0);
        // start an add and reset it while in EXEC
        run = 1'b1; opcode = 6'b000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd6)
            begin errors++; $display("FAIL abort_setup: state=%0d need 6", state); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0 || state !== 4'd0 || instr_cnt !== 32'd0)
            begin errors++; $display("FAIL abort: sig=%h state=%0d cnt=%0d, need all 0", obs, state, instr_cnt); end
        repeat (2) @(posedge clk);
        #1;
        run = 1'b0;
        rst = 1'b0;
        cnt_model = 32'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (state !== 4'd0 || obs !== 18'd0 || instr_cnt !== 32'd0)
                begin errors++; $display("FAIL idle_after_reset cyc=%0d: state=%0d sig=%h cnt=%0d, need 0", c, state, obs, instr_cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        do_instr(6'b100011, 0, 1'b0);
        checks++;
        if (instr_cnt !== 32'd1)
            begin errors++; $display("FAIL lw_count: got %0d need 1", instr_cnt); end
    endtask

    task automatic test_back_to_back();
        do_instr(6'b101011, 0, 1'b0);
        do_instr(6'b000000, 0, 1'b0);
        checks++;
        if (instr_cnt !== 32'd3)
            begin errors++; $display("FAIL b2b_count: got %0d need 3", instr_cnt); end
    endtask

    task automatic test_branch_jump();
        do_instr(6'b000100, 1, 1'b0);
        do_instr(6'b000010, 0, 1'b0);
    endtask

    task automatic test_illegal();
        do_instr(6'b111111, 0, 1'b0);
        for (int k = 0; k < 4; k++) do_instr(rand_illegal(), 0, 1'b0);
    endtask

    task automatic test_wrap();
        while (cnt_model[3:0] != 4'd15) do_instr(rand_legal(), 0, 1'b0);
        checks++;
        if (w_instr_cnt !== 4'd15)
            begin errors++; $display("FAIL preset: got %0d need 15", w_instr_cnt); end
        do_instr(6'b001000, 0, 1'b1);
        checks++;
        if (w_instr_cnt !== 4'd0)
            begin errors++; $display("FAIL wrap: got %0d need 0", w_instr_cnt); end
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (state !== 4'd0 || PCWrite !== 1'b0 || obs !== 18'd0)
                begin errors++; $display("FAIL hold_fetch cyc=%0d: state=%0d PCWrite=%b", c, state, PCWrite); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) < 8) ? rand_legal() : rand_illegal();
            do_instr(op, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 6'd0;
        test_reset();
        test_abort();
        test_lw();
        test_back_to_back();
        test_branch_jump();
        test_illegal();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Consumes the opcode from the instruction register. Drives every datapath enable and mux select: PC, memory, IR, register file, ALU operand muxes and ALU-op field.
- Supports add, addi, lw, sw, beq and j.
- Exposes a `run` gate at instruction boundaries for the debug/step unit, plus a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter instr_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
run  in  1  1 = allow fetch of next instruction; sampled only in FETCH
opcode  in  6  instruction[31:26] from IR; valid from DECODE onward
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zf=1
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load
MemtoReg  out  1  RF write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  RF write addr: 0 = rt, 1 = rd
RegWrite  out  1  RF write enable
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  out  4  current state encoding (debug)
instr_done  out  1  one-cycle pulse in last cycle of each instruction
illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode
instr_cnt  out  CNT_WIDTH  count of instr_done pulses since reset

Behaviour:
- Reset: state register, instr_cnt and all outputs go to 0 immediately on rst=1 (async) and stay 0 while rst is high. After release the FSM is in FETCH.
- Outputs are Moore (decoded from state only), except FETCH, which is gated by run. Any output not listed for a state is 0.
- State encoding 0-11:
  - 0 FETCH: if run: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1. If !run: all 0; hold in FETCH.
  - 1 DECODE: ALUSrcB=11.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10.
  - 3 MEMRD: MemRead=1, IorD=1.
  - 4 MEMWB: MemtoReg=1, RegWrite=1.
  - 5 MEMWR: MemWrite=1, IorD=1.
  - 6 EXEC: ALUSrcA=1, ALUOp=10.
  - 7 RWB: RegDst=1, RegWrite=1.
  - 8 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - 9 JUMP: PCWrite=1, PCSource=10.
  - 10 ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - 11 ADDIWB: RegWrite=1.
  - Codes 12-15 are unused and go to FETCH on the next edge, with no pulses.
- Transitions:
  - FETCH goes to DECODE when run=1.
  - DECODE branches on opcode:
    - 100011 or 101011 → MEMADR
    - 000000 → EXEC
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDIEX
    - other → FETCH with illegal=1
  - MEMADR goes to MEMRD for 100011 and to MEMWR otherwise.
  - MEMRD → MEMWB; EXEC → RWB; ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RWB, BRANCH, JUMP and ADDIWB all go to FETCH.
- Latency, FETCH to last state inclusive: lw 5, sw/add/addi 4, beq/j 3, illegal 2 cycles.
- instr_done is 1 in MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB, and in DECODE when the opcode is illegal.
- instr_cnt increments by 1 on each clock edge where instr_done=1. It wraps from all-ones to 0.
- run only matters in FETCH. Deasserting run mid-instruction does not stall; the instruction completes and the FSM then holds in FETCH.
- Reset asserted mid-instruction aborts it: no write strobes are issued after rst rises and instr_cnt clears.
- opcode is sampled in DECODE and MEMADR only; changes in other states are ignored.

Test Plan:
1. rst=1 mid-EXEC → all outputs 0 same cycle; after release with run=0, state=0 and all enables stay 0 for 10 cycles.
2. run=1, opcode=100011 → states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in cycle 5; instr_done pulses once; instr_cnt=1.
3. opcode=101011 then 000000 back-to-back → sw: MemWrite=1 with IorD=1 in cycle 4; add: RegDst=1 and RegWrite=1 in cycle 8; instr_cnt=2.
4. opcode=000100 → BRANCH in cycle 3 with PCWriteCond=1, PCSource=01, ALUOp=01. opcode=000010 → PCWrite=1, PCSource=10 in cycle 3.
5. opcode=111111 → illegal=1 and instr_done=1 in DECODE; next cycle state=0; no RegWrite or MemWrite asserted.
6. Preset counter at CNT_WIDTH=4 to 15, execute one addi → instr_cnt wraps to 0. Drop run in cycle 2 of addi → addi finishes at ADDIWB, then FSM holds in FETCH with PCWrite=0.
